// File: rtl/servo_pkg.sv
// Shared servo PWM link constants, used by both the pulse generator and the capture side
// so the position encoding stays consistent.
package servo_pkg;

  localparam int unsigned SERVO_MIN_US     = 1000;
  localparam int unsigned SERVO_MAX_US     = 2000;
  localparam int unsigned SERVO_FRAME_US   = 20000;
  localparam int unsigned SERVO_TIMEOUT_US = 25000;
  localparam int unsigned CLKS_PER_US      = 100;
  localparam int unsigned POS_W            = 10;
  localparam int unsigned WIDTH_W          = 12;
  localparam int unsigned FRAME_W          = 15;

  typedef enum logic [1:0] {
    StWaitLow,
    StIdle,
    StHigh
  } cap_state_e;

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CLKS_PER_US clocks, restartable with clr.
module us_tick_gen #(
  parameter int unsigned CLKS_PER_US = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntW'(CLKS_PER_US - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/servo_pwm_capture.sv
// Servo PWM receiver: measures pulse high time in microseconds, converts it to a position
// word, and flags out-of-range pulses and loss of signal.
module servo_pwm_capture #(
  parameter int unsigned CLKS_PER_US = servo_pkg::CLKS_PER_US,
  parameter int unsigned MIN_US      = servo_pkg::SERVO_MIN_US,
  parameter int unsigned MAX_US      = servo_pkg::SERVO_MAX_US,
  parameter int unsigned TIMEOUT_US  = servo_pkg::SERVO_TIMEOUT_US
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pwm_in,
  output logic [servo_pkg::POS_W-1:0] pos,
  output logic                       pos_valid,
  output logic                       err_range,
  output logic                       signal_lost
);

  import servo_pkg::*;

  localparam int unsigned WidthMax = (1 << WIDTH_W) - 1;

  logic               sync1_q, sync2_q, hist_q;
  logic               rise_q, fall_q;
  logic               tick, timeout_hit, in_range;
  logic [WIDTH_W-1:0] width_q, width_next;
  logic [FRAME_W-1:0] frame_q;
  cap_state_e         state_q;
  logic [POS_W-1:0]   pos_q;
  logic               pos_valid_q, err_range_q, signal_lost_q;

  // Synchronizer and history are deliberately not reset: a pulse in flight across reset
  // must not look like a fresh rising edge once reset releases.
  always_ff @(posedge clk) begin
    sync1_q <= pwm_in;
    sync2_q <= sync1_q;
    hist_q  <= sync2_q;
  end

  // Edge strobes are registered so strobes land three edges after the input sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= sync2_q & ~hist_q;
      fall_q <= ~sync2_q & hist_q;
    end
  end

  us_tick_gen #(
    .CLKS_PER_US(CLKS_PER_US)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (rise_q),
    .tick(tick)
  );

  always_comb begin
    width_next = width_q;
    if (state_q == StHigh && tick && width_q != WIDTH_W'(WidthMax)) begin
      width_next = width_q + 1'b1;
    end
  end

  assign in_range    = (width_next >= WIDTH_W'(MIN_US)) && (width_next <= WIDTH_W'(MAX_US));
  assign timeout_hit = tick && !rise_q && (frame_q == FRAME_W'(TIMEOUT_US - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      width_q <= '0;
      frame_q <= '0;
    end else if (rise_q) begin
      width_q <= '0;
      frame_q <= '0;
    end else begin
      width_q <= width_next;
      if (tick && frame_q < FRAME_W'(TIMEOUT_US)) begin
        frame_q <= frame_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StWaitLow;
      pos_q         <= '0;
      pos_valid_q   <= 1'b0;
      err_range_q   <= 1'b0;
      signal_lost_q <= 1'b1;
    end else begin
      pos_valid_q <= 1'b0;
      err_range_q <= 1'b0;
      if (timeout_hit) begin
        signal_lost_q <= 1'b1;
      end
      unique case (state_q)
        StWaitLow: begin
          if (!sync2_q) state_q <= StIdle;
        end
        StIdle: begin
          if (rise_q) state_q <= StHigh;
        end
        StHigh: begin
          if (fall_q) begin
            state_q <= StIdle;
            if (in_range) begin
              pos_q         <= POS_W'(width_next - WIDTH_W'(MIN_US));
              pos_valid_q   <= 1'b1;
              // Later assignment overrides a coincident timeout: the accepted pulse wins.
              signal_lost_q <= 1'b0;
            end else begin
              err_range_q <= 1'b1;
            end
          end else if (width_next == WIDTH_W'(WidthMax)) begin
            err_range_q <= 1'b1;
            state_q     <= StWaitLow;
          end
        end
        default: state_q <= StWaitLow;
      endcase
    end
  end

  assign pos         = pos_q;
  assign pos_valid   = pos_valid_q;
  assign err_range   = err_range_q;
  assign signal_lost = signal_lost_q;

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Scoreboard bench for servo_pwm_capture: pulses are issued with known widths, a reference
// model predicts each strobe/loss event, and a monitor checks them as the DUT produces them.
module tb_servo_pwm_capture;

  localparam int unsigned C     = 2;     // clocks per microsecond in this bench
  localparam int unsigned T     = 4500;  // timeout in microseconds in this bench
  localparam int unsigned MINW  = 1000;
  localparam int unsigned MAXW  = 2000;
  localparam int unsigned SAT   = 4095;
  localparam int unsigned GAP   = 200 * C;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm_in;
  logic [9:0] pos;
  logic       pos_valid, err_range, signal_lost;

  servo_pwm_capture #(
    .CLKS_PER_US(C),
    .MIN_US     (MINW),
    .MAX_US     (MAXW),
    .TIMEOUT_US (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .pos        (pos),
    .pos_valid  (pos_valid),
    .err_range  (err_range),
    .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EvValid, EvErr, EvLost} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int unsigned cyc;
    int unsigned pos;
    bit          lost;
  } ev_t;

  ev_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned m_pos  = 0;
  bit          m_lost = 1'b1;
  bit          mon_en = 1'b0;
  bit          prev_lost = 1'b1;

  function automatic void check(string name, int unsigned act, int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void push(ev_kind_e k, int unsigned c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.pos  = m_pos;
    e.lost = m_lost;
    exp_q.push_back(e);
  endfunction

  function automatic int unsigned us(int unsigned x);
    return x * C;
  endfunction

  // Drive a high pulse of n clocks then l clocks low; the model predicts the outcome from
  // the pulse length alone. Called on a negative edge; the next pulse follows immediately.
  task automatic pulse(input int unsigned n, input int unsigned l);
    int unsigned ea, w, tout;
    pwm_in = 1'b1;
    ea = cyc + 1;
    w  = n / C;
    if (w >= SAT) begin
      push(EvErr, ea + 3 + SAT * C);
    end else if (w >= MINW && w <= MAXW) begin
      m_pos  = w - MINW;
      m_lost = 1'b0;
      push(EvValid, ea + n + 3);
    end else begin
      push(EvErr, ea + n + 3);
    end
    tout = ea + 3 + T * C;
    if (!m_lost && tout < ea + n + l + 3) begin
      m_lost = 1'b1;
      push(EvLost, tout);
    end
    repeat (n) @(negedge clk);
    pwm_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  // Pulse interrupted by reset: the partial measurement must produce no strobe.
  task automatic reset_mid_pulse(input int unsigned n1, input int unsigned n2,
                                 input int unsigned l);
    pwm_in = 1'b1;
    repeat (n1) @(negedge clk);
    rst   = 1'b1;
    m_pos = 0;
    if (!m_lost) begin
      m_lost = 1'b1;
      push(EvLost, cyc + 1);
    end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (n2) @(negedge clk);
    pwm_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    ev_t      e;
    ev_kind_e kind;
    if (mon_en) begin
      if (pos_valid || err_range || (signal_lost && !prev_lost)) begin
        kind = pos_valid ? EvValid : (err_range ? EvErr : EvLost);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", int'(kind), int'(e.kind));
          check("event_cycle", cyc, e.cyc);
          check("pos", pos, e.pos);
          check("signal_lost", signal_lost, e.lost);
          check("strobe_exclusive", pos_valid && err_range, 0);
        end
      end
      prev_lost = signal_lost;
    end
  end

  initial begin
    int unsigned w, n;
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    check("reset_pos", pos, 0);
    check("reset_pos_valid", pos_valid, 0);
    check("reset_err_range", err_range, 0);
    check("reset_signal_lost", signal_lost, 1);
    rst       = 1'b0;
    prev_lost = 1'b1;
    mon_en    = 1'b1;
    repeat (5) @(negedge clk);

    repeat (3) pulse(us(1500), GAP);
    pulse(us(1000), GAP);
    pulse(us(2000), GAP);
    pulse(us(999) + 1, GAP);
    pulse(us(2001), us(3000));
    pulse(us(1200), GAP);
    reset_mid_pulse(us(800), us(700), GAP);
    pulse(us(1700), GAP);
    pulse(us(5000), GAP);
    pulse(us(1500), GAP);
    repeat (3) begin
      w = $urandom_range(950, 2060);
      n = us(w) + $urandom_range(0, C - 1);
      pulse(n, us($urandom_range(100, 300)));
    end
    pulse(us(1600), us(3000));

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
